// File: rtl/ctrl_word_arbiter.sv
// ctrl_word_arbiter: round-robin arbiter that grants whole multi-beat control-word sequences onto one registered datapath port
//   clk, rst (async, active-high)
//   req_valid/req_cw/req_last/req_ready : NREQ requester handshakes, word i at req_cw[i*CW_W +: CW_W]
//   dp_valid/dp_cw/dp_ready             : registered output stage towards the datapath
//   grant_id, busy                      : current/last owner, grant held
//   timeout_err                         : sticky flag, set when an idle owner was forcibly released
module ctrl_word_arbiter #(
    parameter int NREQ      = 2,
    parameter int CW_W      = 29,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*CW_W-1:0] req_cw,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    output logic                 dp_valid,
    output logic [CW_W-1:0]      dp_cw,
    input  logic                 dp_ready,
    output logic [1:0]           grant_id,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic {IDLE, LOCK} state_t;
    state_t          r_state;
    logic [1:0]      r_rr_ptr;
    logic [BW-1:0]   r_beat_cnt;
    logic [TW-1:0]   r_idle_cnt;
    logic [2*NREQ-1:0] w_rot;
    logic [1:0]      w_win;
    logic [1:0]      w_next;
    logic [NREQ-1:0] w_onehot;
    logic [CW_W-1:0] w_word;
    logic            w_out_free;
    logic            w_own_valid;
    logic            w_own_last;
    logic            w_acc;
    logic            w_burst_end;
    logic            w_idle_end;
    // rotate so that bit k is requester (rr_ptr + k) mod NREQ; lowest set bit wins
    assign w_rot = {req_valid, req_valid} >> r_rr_ptr;
    always_comb begin
        w_win = r_rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--)
            if (w_rot[k]) w_win = 2'((int'(r_rr_ptr) + k) % NREQ);
    end
    assign busy        = r_state == LOCK;
    assign w_onehot    = NREQ'(1) << grant_id;
    assign w_word      = CW_W'(req_cw >> (int'(grant_id) * CW_W));
    assign w_own_valid = |(req_valid & w_onehot);
    assign w_own_last  = |(req_last & w_onehot);
    assign w_out_free  = !dp_valid | dp_ready;
    assign req_ready   = busy && w_out_free ? w_onehot : '0;
    assign w_acc       = busy & w_own_valid & w_out_free;
    assign w_burst_end = r_beat_cnt == BW'(MAX_BURST - 1);
    assign w_idle_end  = !w_own_valid & (r_idle_cnt == TW'(TIMEOUT - 1));
    assign w_next      = grant_id == 2'(NREQ - 1) ? 2'd0 : grant_id + 2'd1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_beat_cnt  <= '0;
            r_idle_cnt  <= '0;
            dp_valid    <= 1'b0;
            dp_cw       <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else if (r_state == IDLE) begin
            // a word left over from the previous grant still drains here
            if (dp_ready) dp_valid <= 1'b0;
            if (|req_valid) begin
                grant_id   <= w_win;
                r_beat_cnt <= '0;
                r_idle_cnt <= '0;
                r_state    <= LOCK;
            end
        end else begin
            if (w_acc) begin
                dp_cw      <= w_word;
                dp_valid   <= 1'b1;
                r_beat_cnt <= r_beat_cnt + 1'b1;
                r_idle_cnt <= '0;
            end else if (w_out_free) begin
                dp_valid <= 1'b0;
            end
            // backpressure with the owner still valid is not idleness
            if (!w_own_valid) r_idle_cnt <= r_idle_cnt + 1'b1;
            if ((w_acc & (w_own_last | w_burst_end)) | w_idle_end) begin
                r_state  <= IDLE;
                r_rr_ptr <= w_next;
            end
            if (w_idle_end) timeout_err <= 1'b1;
        end
    end
endmodule
